// File: rtl/dpll_loop_if.sv
// Signal bundle between the DPLL loop controller and its DCO/data front end.
// The master drives the data stream and recovered clock; the slave (controller) drives the DCO controls and status.
interface dpll_loop_if;
    logic       data_in;
    logic       clk_para;
    logic       carry_pulse;
    logic       subtraction_pulse;
    logic       both_edge;
    logic       locked;
    logic [1:0] state;
    logic [7:0] drift;

    modport master (
        output data_in, clk_para,
        input  carry_pulse, subtraction_pulse, both_edge, locked, state, drift
    );

    modport slave (
        input  data_in, clk_para,
        output carry_pulse, subtraction_pulse, both_edge, locked, state, drift
    );
endinterface

// File: rtl/dpll_loop_ctrl.sv
// Loop controller for the DPSK bit-clock DPLL: edge detection, early/late K-counter filter, drift limit, lock FSM.
// Optional DPLL_HOLDOVER_EN: a timeout while LOCKED falls back to TRACK (DCO free-runs) instead of IDLE.
//
//  state  | meaning
//  IDLE   | no signal; first data edge phase-resets the DCO and starts acquisition
//  ACQ    | fast pull-in with K_ACQ, both_edge on every edge
//  TRACK  | low-jitter filtering with K_TRK, counting clean edges toward lock
//  LOCKED | tracking; a drift-limit hit means the frequency is out of range
module dpll_loop_ctrl #(
    parameter int K_ACQ     = 2,
    parameter int K_TRK     = 8,
    parameter int ACQ_EDGES = 4,
    parameter int LOCK_CNT  = 32,
    parameter int MAX_DRIFT = 8,
    parameter int TIMEOUT   = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    dpll_loop_if.slave  bus_if
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACQ    = 2'd1;
    localparam logic [1:0] TRACK  = 2'd2;
    localparam logic [1:0] LOCKED = 2'd3;

    localparam logic signed [7:0] KACQ_TOP  = 8'(K_ACQ - 1);
    localparam logic signed [7:0] KTRK_TOP  = 8'(K_TRK - 1);
    localparam logic signed [7:0] DRIFT_MAX = 8'(MAX_DRIFT);
    localparam logic [7:0]        ACQ_LAST  = 8'(ACQ_EDGES - 1);
    localparam logic [7:0]        LOCK_LAST = 8'(LOCK_CNT - 1);
    localparam logic [15:0]       TMR_LOAD  = 16'(TIMEOUT);

    logic              s1_q, s2_q, s3_q;
    logic [1:0]        state_q, state_d;
    logic signed [7:0] kcnt_q, kcnt_d;
    logic signed [7:0] drift_q, drift_d;
    logic [7:0]        edge_cnt_q, edge_cnt_d;
    logic [15:0]       tmr_q, tmr_d;
    logic              carry_q, carry_d;
    logic              sub_q, sub_d;
    logic              both_q, both_d;

    logic              data_edge;
    logic signed [7:0] k_top;
    logic              ovf, supp;

    assign data_edge = s2_q ^ s3_q;
    assign k_top     = (state_q == ACQ) ? KACQ_TOP : KTRK_TOP;

    always_comb begin
        state_d    = state_q;
        kcnt_d     = kcnt_q;
        drift_d    = drift_q;
        edge_cnt_d = edge_cnt_q;
        tmr_d      = tmr_q;
        carry_d    = 1'b0;
        sub_d      = 1'b0;
        both_d     = 1'b0;
        ovf        = 1'b0;
        supp       = 1'b0;

        if (data_edge) begin
            tmr_d  = TMR_LOAD;
            both_d = (state_q == IDLE) || (state_q == ACQ);
            // clk_para high at the edge means the DCO is running early
            if (state_q != IDLE) begin
                if (!bus_if.clk_para) begin
                    if (kcnt_q == k_top) begin
                        ovf    = 1'b1;
                        kcnt_d = '0;
                        if (drift_q == DRIFT_MAX) begin
                            supp = 1'b1;
                        end else begin
                            carry_d = 1'b1;
                            drift_d = drift_q + 8'sd1;
                        end
                    end else begin
                        kcnt_d = kcnt_q + 8'sd1;
                    end
                end else begin
                    if (kcnt_q == -k_top) begin
                        ovf    = 1'b1;
                        kcnt_d = '0;
                        if (drift_q == -DRIFT_MAX) begin
                            supp = 1'b1;
                        end else begin
                            sub_d   = 1'b1;
                            drift_d = drift_q - 8'sd1;
                        end
                    end else begin
                        kcnt_d = kcnt_q - 8'sd1;
                    end
                end
            end

            case (state_q)
                IDLE:   state_d = ACQ;
                ACQ: begin
                    if (edge_cnt_q == ACQ_LAST) state_d = TRACK;
                    else                        edge_cnt_d = edge_cnt_q + 8'd1;
                end
                TRACK: begin
                    if (ovf)                          edge_cnt_d = '0;
                    else if (edge_cnt_q == LOCK_LAST) state_d = LOCKED;
                    else                              edge_cnt_d = edge_cnt_q + 8'd1;
                end
                default: begin
                    if (supp) state_d = ACQ;
                end
            endcase
        end else if (state_q != IDLE) begin
            if (tmr_q == 16'd1) begin
`ifdef DPLL_HOLDOVER_EN
                if (state_q == LOCKED) begin
                    state_d = TRACK;
                    tmr_d   = TMR_LOAD;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end else if (tmr_q != 16'd0) begin
                tmr_d = tmr_q - 16'd1;
            end
        end

        if (state_d != state_q) begin
            kcnt_d     = '0;
            edge_cnt_d = '0;
        end
        if (state_d == IDLE) tmr_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            state_q    <= IDLE;
            kcnt_q     <= '0;
            drift_q    <= '0;
            edge_cnt_q <= '0;
            tmr_q      <= '0;
            carry_q    <= 1'b0;
            sub_q      <= 1'b0;
            both_q     <= 1'b0;
        end else begin
            s1_q       <= bus_if.data_in;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            state_q    <= state_d;
            kcnt_q     <= kcnt_d;
            drift_q    <= drift_d;
            edge_cnt_q <= edge_cnt_d;
            tmr_q      <= tmr_d;
            carry_q    <= carry_d;
            sub_q      <= sub_d;
            both_q     <= both_d;
        end
    end

    assign bus_if.carry_pulse       = carry_q;
    assign bus_if.subtraction_pulse = sub_q;
    assign bus_if.both_edge         = both_q;
    assign bus_if.locked            = (state_q == LOCKED);
    assign bus_if.state             = state_q;
    assign bus_if.drift             = drift_q;

endmodule
